// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks: lifecycle states, food kinds
// and the default scoring constants.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_ADD     = 2'd2,
        ST_OVER    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        EAT_NORMAL = 2'd0,
        EAT_BONUS  = 2'd1,
        EAT_RSVD2  = 2'd2,
        EAT_RSVD3  = 2'd3
    } eat_kind_e;

    localparam int SCORE_MAX_DEF    = 255;
    localparam int PTS_NORMAL_DEF   = 1;
    localparam int PTS_BONUS_DEF    = 5;
    localparam int COMBO_WINDOW_DEF = 50;
    localparam int MAX_MULT_DEF     = 3;
    localparam int LEVEL_STEP_DEF   = 16;
    localparam int MAX_LEVEL_DEF    = 7;

endpackage

// File: rtl/combo_timer.sv
// Combo window down-counter: reloads on an accepted eat, counts down while
// enabled, and reports whether the window is still open.
module combo_timer #(
    parameter int WINDOW = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic load_i,
    input  logic en_i,
    output logic active_o
);

    localparam int CW = $clog2(WINDOW + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = CW'(WINDOW);
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign active_o = (count_q != '0);

endmodule

// File: rtl/score_tracker.sv
// Game score engine: accepts food events, applies combo multiplier with
// saturation, tracks level and high score, and sequences IDLE/PLAYING/ADD/OVER.
module score_tracker
    import snake_pkg::*;
#(
    parameter int SCORE_MAX    = SCORE_MAX_DEF,
    parameter int PTS_NORMAL   = PTS_NORMAL_DEF,
    parameter int PTS_BONUS    = PTS_BONUS_DEF,
    parameter int COMBO_WINDOW = COMBO_WINDOW_DEF,
    parameter int MAX_MULT     = MAX_MULT_DEF,
    parameter int LEVEL_STEP   = LEVEL_STEP_DEF,
    parameter int MAX_LEVEL    = MAX_LEVEL_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dbg_rst_n,
    input  logic        new_game,
    input  logic        eat_valid,
    input  logic [1:0]  eat_kind,
    output logic        eat_ready,
    input  logic        game_over,
    output logic [31:0] score,
    output logic [7:0]  high_score,
    output logic [2:0]  level,
    output logic [1:0]  mult,
    output logic [1:0]  state_dbg
);

    localparam int LEVEL_SHIFT = $clog2(LEVEL_STEP);

    state_e     state_q, state_d;
    logic [7:0] score_q, score_d;
    logic [7:0] hs_q, hs_d;
    logic [2:0] level_q, level_d;
    logic [1:0] mult_q, mult_d;
    logic [7:0] pts_q, pts_d;

    logic       accept;
    logic       game_clear;
    logic       combo_active;
    logic [7:0] prod;
    logic [8:0] sum_w;
    logic [7:0] sat_score;
    logic [7:0] lvl_raw;

    combo_timer #(
        .WINDOW (COMBO_WINDOW)
    ) u_combo_timer (
        .clk      (clk),
        .rst_n    (reset_n),
        .clr_i    (!dbg_rst_n || game_clear),
        .load_i   (accept),
        .en_i     ((state_q == ST_PLAYING) || (state_q == ST_ADD)),
        .active_o (combo_active)
    );

    // The 9-bit sum cannot wrap, so a single compare gives the saturated score.
    assign prod      = pts_q * {6'd0, mult_q};
    assign sum_w     = {1'b0, score_q} + {1'b0, prod};
    assign sat_score = (sum_w > 9'(SCORE_MAX)) ? 8'(SCORE_MAX) : sum_w[7:0];
    assign lvl_raw   = sat_score >> LEVEL_SHIFT;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        hs_d       = hs_q;
        level_d    = level_q;
        mult_d     = mult_q;
        pts_d      = pts_q;
        accept     = 1'b0;
        game_clear = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (new_game) begin
                    state_d    = ST_PLAYING;
                    game_clear = 1'b1;
                end
            end
            ST_PLAYING: begin
                if (game_over) begin
                    state_d = ST_OVER;
                end else if (eat_valid) begin
                    accept  = 1'b1;
                    state_d = ST_ADD;
                    case (eat_kind)
                        EAT_NORMAL: pts_d = 8'(PTS_NORMAL);
                        EAT_BONUS:  pts_d = 8'(PTS_BONUS);
                        default:    pts_d = 8'd0;
                    endcase
                    if (!combo_active) begin
                        mult_d = 2'd1;
                    end else if (mult_q < 2'(MAX_MULT)) begin
                        mult_d = mult_q + 2'd1;
                    end
                end
            end
            ST_ADD: begin
                score_d = sat_score;
                level_d = (lvl_raw > 8'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : lvl_raw[2:0];
                state_d = game_over ? ST_OVER : ST_PLAYING;
            end
            default: state_d = ST_IDLE;
        endcase

        if (game_clear) begin
            score_d = 8'd0;
            level_d = 3'd0;
            mult_d  = 2'd1;
        end

        // Uses score_d so an add completing on the way into OVER is counted.
        if ((state_d == ST_OVER) && (state_q != ST_OVER) && (score_d > hs_q)) begin
            hs_d = score_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            score_q <= 8'd0;
            hs_q    <= 8'd0;
            level_q <= 3'd0;
            mult_q  <= 2'd1;
            pts_q   <= 8'd0;
        end else if (!dbg_rst_n) begin
            state_q <= ST_IDLE;
            score_q <= 8'd0;
            hs_q    <= 8'd0;
            level_q <= 3'd0;
            mult_q  <= 2'd1;
            pts_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            hs_q    <= hs_d;
            level_q <= level_d;
            mult_q  <= mult_d;
            pts_q   <= pts_d;
        end
    end

    assign eat_ready  = (state_q == ST_PLAYING);
    assign score      = {24'd0, score_q};
    assign high_score = hs_q;
    assign level      = level_q;
    assign mult       = mult_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: scoring, combo, saturation, lifecycle,
// high score and both reset paths, with hand-computed expectations.
module tb_score_tracker;

    logic        clk;
    logic        reset_n;
    logic        dbg_rst_n;
    logic        new_game;
    logic        eat_valid;
    logic [1:0]  eat_kind;
    logic        eat_ready;
    logic        game_over;
    logic [31:0] score;
    logic [7:0]  high_score;
    logic [2:0]  level;
    logic [1:0]  mult;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_err    = 0;

    score_tracker dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dbg_rst_n  (dbg_rst_n),
        .new_game   (new_game),
        .eat_valid  (eat_valid),
        .eat_kind   (eat_kind),
        .eat_ready  (eat_ready),
        .game_over  (game_over),
        .score      (score),
        .high_score (high_score),
        .level      (level),
        .mult       (mult),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_score"}, score, 32'd0);
        chk({tag, "_hs"},    32'(high_score), 32'd0);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_mult"},  32'(mult), 32'd1);
        chk({tag, "_state"}, 32'(state_dbg), 32'd0);
        chk({tag, "_ready"}, 32'(eat_ready), 32'd0);
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    // One accepted eat: capture edge, then ADD edge; score visible after the second.
    task automatic do_eat(input string tag, input logic [1:0] kind, input int exp_score,
                          input int exp_mult, input int exp_level, input int gap);
        chk({tag, "_ready_pre"}, 32'(eat_ready), 32'd1);
        eat_valid = 1'b1;
        eat_kind  = kind;
        tick();
        eat_valid = 1'b0;
        eat_kind  = 2'd0;
        chk({tag, "_state_add"}, 32'(state_dbg), 32'd2);
        chk({tag, "_ready_add"}, 32'(eat_ready), 32'd0);
        chk({tag, "_mult"},      32'(mult), 32'(exp_mult));
        tick();
        chk({tag, "_score"},     score, 32'(exp_score));
        chk({tag, "_level"},     32'(level), 32'(exp_level));
        chk({tag, "_state_ret"}, 32'(state_dbg), 32'd1);
        repeat (gap) tick();
    endtask

    initial begin
        int s;
        int lv;

        reset_n   = 1'b0;
        dbg_rst_n = 1'b1;
        new_game  = 1'b0;
        eat_valid = 1'b0;
        eat_kind  = 2'd0;
        game_over = 1'b0;

        // Reset values
        repeat (3) tick();
        chk_reset_vals("rst");
        reset_n = 1'b1;
        tick();
        chk("idle_hold", 32'(state_dbg), 32'd0);

        // 1: normal eats far apart, multiplier stays 1
        pulse_new_game();
        chk("ng1_state", 32'(state_dbg), 32'd1);
        do_eat("t1a", 2'd0, 1, 1, 0, 98);
        do_eat("t1b", 2'd0, 2, 1, 0, 98);
        do_eat("t1c", 2'd0, 3, 1, 0, 2);
        pulse_new_game();
        chk("midgame_ng_score", score, 32'd3);
        chk("midgame_ng_state", 32'(state_dbg), 32'd1);
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        chk("go1_state", 32'(state_dbg), 32'd3);
        chk("go1_hs", 32'(high_score), 32'd3);
        pulse_new_game();
        chk("ng2_score", score, 32'd0);
        chk("ng2_hs", 32'(high_score), 32'd3);

        // 2: bonus combo 10 cycles apart
        do_eat("t2a", 2'd1, 5, 1, 0, 8);
        do_eat("t2b", 2'd1, 15, 2, 0, 8);
        do_eat("t2c", 2'd1, 30, 3, 1, 8);

        // 4: game_over and eat together -> eat dropped
        eat_valid = 1'b1;
        eat_kind  = 2'd1;
        game_over = 1'b1;
        tick();
        eat_valid = 1'b0;
        game_over = 1'b0;
        chk("t4_state", 32'(state_dbg), 32'd3);
        chk("t4_score", score, 32'd30);
        chk("t4_hs", 32'(high_score), 32'd30);
        tick();
        chk("t4_score_hold", score, 32'd30);
        chk("t4_ready_over", 32'(eat_ready), 32'd0);
        pulse_new_game();
        chk("t4_ng_score", score, 32'd0);
        chk("t4_ng_hs", 32'(high_score), 32'd30);
        chk("t4_ng_mult", 32'(mult), 32'd1);

        // 5a: lower game, game_over pulsed during ADD
        eat_valid = 1'b1;
        eat_kind  = 2'd1;
        tick();
        eat_valid = 1'b0;
        chk("t5a_state_add", 32'(state_dbg), 32'd2);
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        chk("t5a_score", score, 32'd5);
        chk("t5a_state", 32'(state_dbg), 32'd3);
        chk("t5a_hs", 32'(high_score), 32'd30);
        pulse_new_game();

        // 3: climb to the ceiling, then saturate
        do_eat("t3a", 2'd1, 5, 1, 0, 8);
        do_eat("t3b", 2'd1, 15, 2, 0, 8);
        do_eat("t3c", 2'd1, 30, 3, 1, 8);
        for (int i = 1; i <= 14; i++) begin
            s  = 30 + 15 * i;
            lv = (s / 16 > 7) ? 7 : s / 16;
            do_eat("t3_climb", 2'd1, s, 3, lv, 8);
        end
        do_eat("t3n1", 2'd0, 243, 3, 7, 8);
        do_eat("t3n2", 2'd0, 246, 3, 7, 8);
        do_eat("t3n3", 2'd0, 249, 3, 7, 8);
        do_eat("t3n4", 2'd0, 252, 3, 7, 60);
        do_eat("t3_253", 2'd0, 253, 1, 7, 60);
        do_eat("t3_sat", 2'd1, 255, 1, 7, 8);
        do_eat("t3_sat2", 2'd0, 255, 2, 7, 8);
        do_eat("t3_rsvd", 2'd2, 255, 3, 7, 2);

        // 5b: higher game updates high score on entry to OVER
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        chk("t5b_state", 32'(state_dbg), 32'd3);
        chk("t5b_hs", 32'(high_score), 32'd255);

        // 6: asynchronous reset in the middle of ADD
        pulse_new_game();
        eat_valid = 1'b1;
        eat_kind  = 2'd1;
        tick();
        eat_valid = 1'b0;
        chk("t6_state_add", 32'(state_dbg), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("t6_async");
        #3;
        reset_n = 1'b1;
        tick();
        chk("t6_after_edge", score, 32'd0);

        // 6b: synchronous debug reset
        pulse_new_game();
        do_eat("t6b", 2'd1, 5, 1, 0, 2);
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        chk("t6b_hs", 32'(high_score), 32'd5);
        dbg_rst_n = 1'b0;
        #2;
        chk("t6b_no_edge_score", score, 32'd5);
        tick();
        dbg_rst_n = 1'b1;
        chk_reset_vals("t6b_dbg");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
